// File: rtl/add_result_checker_if.sv
// rtl/add_result_checker_if.sv - stimulus/response and result bus of the add-by-one result checker
interface add_result_checker_if #(
   parameter int WL    = 8,
   parameter int CNT_W = 16
);
   logic             I_START;
   logic             I_VALID;
   logic [WL-1:0]    I_STIM;
   logic [WL-1:0]    I_RESP;
   logic             O_BUSY;
   logic             O_DONE;
   logic             O_PASS;
   logic             O_ERR;
   logic [CNT_W-1:0] O_CHK_CNT;
   logic [CNT_W-1:0] O_ERR_CNT;
   logic [WL-1:0]    O_FIRST_ERR_STIM;
   logic [WL-1:0]    O_FIRST_ERR_RESP;

   // Stimulus side: drives start/valid/stimulus/response, observes results
   modport master (
      output I_START, I_VALID, I_STIM, I_RESP,
      input  O_BUSY, O_DONE, O_PASS, O_ERR, O_CHK_CNT, O_ERR_CNT,
             O_FIRST_ERR_STIM, O_FIRST_ERR_RESP
   );

   // Checker side
   modport slave (
      input  I_START, I_VALID, I_STIM, I_RESP,
      output O_BUSY, O_DONE, O_PASS, O_ERR, O_CHK_CNT, O_ERR_CNT,
             O_FIRST_ERR_STIM, O_FIRST_ERR_RESP
   );
endinterface

// File: rtl/add_result_checker.sv
// rtl/add_result_checker.sv - checks add-by-one responses against delayed stimulus + 1
module add_result_checker #(
   parameter int WL        = 8,
   parameter int LATENCY   = 0,
   parameter int N_SAMPLES = 1024,
   parameter int CNT_W     = 16
) (
   input  logic               W_clk,
   input  logic               W_rst,
   add_result_checker_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Fill counter value at which the last pre-compare sample enters the delay line
   localparam logic [3:0]       LP_FILL_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [CNT_W-1:0] LP_N_SAMPLES = CNT_W'(N_SAMPLES);

   state_t           r_state;
   state_t           w_next_state;

   logic [3:0]       r_fill_cnt;
   logic [CNT_W-1:0] r_chk_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_err;
   logic             r_pass;
   logic [WL-1:0]    r_first_err_stim;
   logic [WL-1:0]    r_first_err_resp;

   logic             w_start;
   logic             w_advance;
   logic             w_compare;
   logic             w_mismatch;
   logic             w_last;
   logic [WL-1:0]    w_dly_stim;
   logic [WL-1:0]    w_expected;
   logic [CNT_W-1:0] w_chk_cnt_next;
   logic [CNT_W-1:0] w_err_cnt_next;

   // A start is only honoured while no run is active; FILL/CHECK ignore it
   assign w_start   = bus.I_START && ((r_state == S_IDLE) || (r_state == S_DONE));

   // The delay line moves on every valid sample of an active run
   assign w_advance = bus.I_VALID && ((r_state == S_FILL) || (r_state == S_CHECK));

   // Compares happen only once the delay line is primed
   assign w_compare = bus.I_VALID && (r_state == S_CHECK);

   // Delay line: stimulus delayed by LATENCY valid samples
   generate
      if (LATENCY > 0) begin : g_dly
         logic [WL-1:0] r_dly [LATENCY];

         // Shift register of stimulus, cleared on reset and on each new run
         always_ff @(posedge W_clk or posedge W_rst) begin
            if (W_rst) begin
               for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
            end else if (w_start) begin
               for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
            end else if (w_advance) begin
               r_dly[0] <= bus.I_STIM;
               for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
            end
         end

         assign w_dly_stim = r_dly[LATENCY-1];
      end else begin : g_no_dly
         assign w_dly_stim = bus.I_STIM;
      end
   endgenerate

   // Expected response wraps in WL bits, so the most positive value maps to the most negative
   assign w_expected     = w_dly_stim + WL'(1);
   assign w_mismatch     = w_compare && (bus.I_RESP != w_expected);
   assign w_chk_cnt_next = r_chk_cnt + CNT_W'(1);
   assign w_last         = w_compare && (w_chk_cnt_next == LP_N_SAMPLES);

   // Error count saturates at all-ones instead of wrapping back to a passing-looking value
   assign w_err_cnt_next = (w_mismatch && (r_err_cnt != {CNT_W{1'b1}}))
                         ? (r_err_cnt + CNT_W'(1)) : r_err_cnt;

   // State register
   always_ff @(posedge W_clk or posedge W_rst) begin
      if (W_rst) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.I_START) w_next_state = (LATENCY > 0) ? S_FILL : S_CHECK;
         end
         S_FILL: begin
            if (bus.I_VALID && (r_fill_cnt == LP_FILL_LAST)) w_next_state = S_CHECK;
         end
         S_CHECK: begin
            if (w_last) w_next_state = S_DONE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Fill counter: valid samples shifted in while priming the delay line
   always_ff @(posedge W_clk or posedge W_rst) begin
      if (W_rst) begin
         r_fill_cnt <= '0;
      end else if (w_start) begin
         r_fill_cnt <= '0;
      end else if ((r_state == S_FILL) && bus.I_VALID) begin
         r_fill_cnt <= r_fill_cnt + 4'd1;
      end
   end

   // Compare bookkeeping: counters, sticky error, first failing pair and final verdict
   always_ff @(posedge W_clk or posedge W_rst) begin
      if (W_rst) begin
         r_chk_cnt        <= '0;
         r_err_cnt        <= '0;
         r_err            <= 1'b0;
         r_pass           <= 1'b0;
         r_first_err_stim <= '0;
         r_first_err_resp <= '0;
      end else if (w_start) begin
         r_chk_cnt        <= '0;
         r_err_cnt        <= '0;
         r_err            <= 1'b0;
         r_pass           <= 1'b0;
         r_first_err_stim <= '0;
         r_first_err_resp <= '0;
      end else if (w_compare) begin
         r_chk_cnt <= w_chk_cnt_next;
         r_err_cnt <= w_err_cnt_next;
         if (w_mismatch && !r_err) begin
            r_err            <= 1'b1;
            r_first_err_stim <= w_dly_stim;
            r_first_err_resp <= bus.I_RESP;
         end
         // Verdict includes the outcome of this final compare
         if (w_last) r_pass <= (w_err_cnt_next == '0);
      end
   end

   assign bus.O_BUSY           = (r_state == S_FILL) || (r_state == S_CHECK);
   assign bus.O_DONE           = (r_state == S_DONE);
   assign bus.O_PASS           = r_pass;
   assign bus.O_ERR            = r_err;
   assign bus.O_CHK_CNT        = r_chk_cnt;
   assign bus.O_ERR_CNT        = r_err_cnt;
   assign bus.O_FIRST_ERR_STIM = r_first_err_stim;
   assign bus.O_FIRST_ERR_RESP = r_first_err_resp;

endmodule
